// File: rtl/uart_rx_fifo.sv
// Synchronizes the receiver frame strobe and buffers frames in a first-word-fall-through circular FIFO.
// Optional macro UART_RX_FIFO_DROP_ERR_EN: discard frames flagged with parity/stop errors, store payload only.
module uart_rx_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_store,
    input  logic [WIDTH-1:0]      bits,
    input  logic                  error_parity,
    input  logic                  error_stop_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_bits,
    output logic [1:0]            out_error,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overrun,
    input  logic                  clear_overrun
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    localparam int EW = WIDTH;
`else
    localparam int EW = WIDTH + 2;
`endif
    localparam logic [DEPTH_LOG2:0] PONE = 1;

    logic                  r_s1, r_s2, r_s3;
    logic [DEPTH_LOG2:0]   r_wptr, r_rptr;
    logic                  r_overrun;
    logic [EW-1:0]         r_mem [DEPTH];

    logic                  w_push, w_pop, w_err, w_full, w_empty, w_wr, w_ovr;
    logic [EW-1:0]         w_wdata, w_head;

    // s1/s2 resynchronize the asynchronous strobe; s3 remembers the previous level for edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= req_store;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_push  = r_s2 & ~r_s3;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]) &&
                     (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]);
    assign w_pop   = ~w_empty & out_ready;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign w_err   = error_parity | error_stop_bit;
    assign w_wdata = bits;
`else
    assign w_err   = 1'b0;
    assign w_wdata = {error_parity, error_stop_bit, bits};
`endif

    // a same-cycle pop frees the slot, so a full FIFO still accepts the push
    assign w_wr  = w_push & ~w_err & (~w_full | w_pop);
    assign w_ovr = w_push & ~w_err & w_full & ~w_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + PONE;
            if (w_pop)
                r_rptr <= r_rptr + PONE;
            if (w_ovr)
                r_overrun <= 1'b1;
            else if (clear_overrun)
                r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr)
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= w_wdata;
    end

    assign w_head    = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    assign out_bits  = w_head[WIDTH-1:0];
`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign out_error = 2'b00;
`else
    assign out_error = w_head[WIDTH+1:WIDTH];
`endif
    assign out_valid = ~w_empty;
    assign count     = r_wptr - r_rptr;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner cases, and randomized traffic vs a queue model.
module tb_uart_rx_fifo;
    localparam int WIDTH = 16;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_store = 1'b0;
    logic [WIDTH-1:0]  bits = '0;
    logic              error_parity = 1'b0;
    logic              error_stop_bit = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_bits;
    logic [1:0]        out_error;
    logic [DL:0]       count;
    logic              full, empty, overrun;
    logic              clear_overrun = 1'b0;

    always #5 clock = ~clock;

    uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DL)) dut (
        .clock(clock), .reset(reset), .req_store(req_store), .bits(bits),
        .error_parity(error_parity), .error_stop_bit(error_stop_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .out_error(out_error), .count(count), .full(full), .empty(empty),
        .overrun(overrun), .clear_overrun(clear_overrun)
    );

`ifdef UART_RX_FIFO_DROP_ERR_EN
    localparam bit KEEP_ERR = 1'b0;
`else
    localparam bit KEEP_ERR = 1'b1;
`endif

    typedef struct { logic [15:0] d; logic [1:0] e; } ent_t;
    ent_t q[$];
    ent_t pend;
    int   cd = 0;
    bit   m_ovr = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: a frame rising before edge k is pushed on edge k+2; pop sees pre-edge occupancy.
    task automatic model_edge();
        bit pop, push, ovr_set;
        pop = (q.size() > 0) && out_ready;
        push = 1'b0;
        ovr_set = 1'b0;
        if (cd > 0) begin
            cd--;
            push = (cd == 0);
        end
        if (pop) void'(q.pop_front());
        if (push && !(!KEEP_ERR && pend.e != 2'b00)) begin
            if (q.size() < DEPTH) q.push_back(pend);
            else ovr_set = 1'b1;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
    endtask

    task automatic check_all();
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (q.size() > 0) begin
            check("out_bits", 32'(out_bits), 32'(q[0].d));
            check("out_error", 32'(out_error), KEEP_ERR ? 32'(q[0].e) : 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic rise(input logic [15:0] d, input logic pe, input logic se);
        bits = d;
        error_parity = pe;
        error_stop_bit = se;
        req_store = 1'b1;
        pend.d = d;
        pend.e = {pe, se};
        cd = 3;
    endtask

    task automatic frame(input logic [15:0] d, input logic pe, input logic se);
        rise(d, pe, se);
        repeat (4) tick();
        req_store = 1'b0;
        repeat (2) tick();
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0] d; logic pe; logic se;
        logic exp_v; logic [15:0] exp_d; logic [1:0] exp_e;
    } vec_t;
    vec_t tv[5];

    initial begin
        tv[0] = '{16'h00A5, 1'b0, 1'b0, 1'b1,     16'h00A5, 2'b00};
        tv[1] = '{16'h00FF, 1'b1, 1'b0, KEEP_ERR, 16'h00FF, KEEP_ERR ? 2'b10 : 2'b00};
        tv[2] = '{16'h1234, 1'b0, 1'b1, KEEP_ERR, 16'h1234, KEEP_ERR ? 2'b01 : 2'b00};
        tv[3] = '{16'hFFFF, 1'b1, 1'b1, KEEP_ERR, 16'hFFFF, KEEP_ERR ? 2'b11 : 2'b00};
        tv[4] = '{16'h0000, 1'b0, 1'b0, 1'b1,     16'h0000, 2'b00};

        // reset state
        repeat (2) @(negedge clock);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        // vector table: single frame, visible within 4 cycles, then one pop
        for (int i = 0; i < 5; i++) begin
            rise(tv[i].d, tv[i].pe, tv[i].se);
            repeat (3) tick();
            check("vec_valid", 32'(out_valid), 32'(tv[i].exp_v));
            check("vec_count", 32'(count), 32'(tv[i].exp_v));
            if (tv[i].exp_v) begin
                check("vec_bits", 32'(out_bits), 32'(tv[i].exp_d));
                check("vec_err", 32'(out_error), 32'(tv[i].exp_e));
            end
            tick();
            req_store = 1'b0;
            repeat (2) tick();
            check("vec_overrun", 32'(overrun), 32'd0);
            pop1();
            check("vec_empty", 32'(empty), 32'd1);
            check("vec_count0", 32'(count), 32'd0);
        end

        // fill and overrun
        for (int i = 1; i <= 5; i++) begin
            frame(16'(i), 1'b0, 1'b0);
            if (i == 4) check("fill_full", 32'(full), 32'd1);
        end
        check("fill_overrun", 32'(overrun), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("fill_drain", 32'(out_bits), 32'(i));
            pop1();
        end
        check("fill_empty", 32'(empty), 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("clr_overrun", 32'(overrun), 32'd0);

        // full with simultaneous pop on the push edge
        for (int i = 0; i < 4; i++) frame(16'h00A0 + 16'(i), 1'b0, 1'b0);
        check("fp_full", 32'(full), 32'd1);
        rise(16'h00B0, 1'b0, 1'b0);
        repeat (2) tick();
        check("fp_head", 32'(out_bits), 32'h00A0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fp_overrun", 32'(overrun), 32'd0);
        check("fp_count", 32'(count), 32'd4);
        tick();
        req_store = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            check("fp_drain", 32'(out_bits), (i < 3) ? 32'h00A1 + 32'(i) : 32'h00B0);
            pop1();
        end

        // wrap-around
        for (int i = 0; i < 10; i++) begin
            frame(16'h0010 + 16'(i), 1'b0, 1'b0);
            check("wrap_count", 32'(count), 32'd1);
            check("wrap_bits", 32'(out_bits), 32'h0010 + 32'(i));
            pop1();
        end

        // reset mid-operation with an edge in the synchronizer
        for (int i = 0; i < 3; i++) frame(16'h0C00 + 16'(i), 1'b0, 1'b0);
        rise(16'h00CC, 1'b0, 1'b0);
        tick();
        #2 reset = 1'b1;
        q.delete();
        cd = 0;
        m_ovr = 1'b0;
        #1;
        check("mr_count", 32'(count), 32'd0);
        check("mr_empty", 32'(empty), 32'd1);
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_overrun", 32'(overrun), 32'd0);
        req_store = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) tick();
        check("mr_nopush", 32'(empty), 32'd1);

        // randomized traffic against the queue model
        begin
            int gt = 0;
            for (int c = 0; c < 3000; c++) begin
                out_ready = (c < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
                clear_overrun = ($urandom_range(0, 40) == 0);
                if (gt == 0) begin
                    if ($urandom_range(0, 2) != 0) begin
                        rise(16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                        gt = 1;
                    end
                end else begin
                    gt++;
                    if (gt == 5) req_store = 1'b0;
                    if (gt >= 7) gt = 0;
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
